// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and
// the legal range of the WIDTH parameter.
package serial_subtractor_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes x - y - b_in.
// This is the subtract-direction counterpart of the full-adder cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  // A borrow is needed when y exceeds x outright, or when they are equal
  // and a borrow arrives from the bit below.
  assign diff  = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), LSB first, one bit per
// clock, behind a start/done handshake. A single full_subtractor cell is
// reused for every bit, with the borrow carried between clocks in bq.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  // Reject widths outside the supported range at elaboration time.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be in 2..64");
  end

  state_t             state;
  logic [WIDTH-1:0]   sa;        // minuend, shifted right each bit
  logic [WIDTH-1:0]   sb;        // subtrahend, shifted right each bit
  logic [WIDTH-1:0]   sr;        // result, filled from the MSB end
  logic               bq;        // borrow carried into the next bit
  logic [CNT_W-1:0]   cnt;       // index of the bit being computed
  logic               a_msb;     // operand sign bits, kept for overflow
  logic               b_msb;
  logic               cell_d;
  logic               cell_b;
  logic               last_bit;

  full_subtractor u_cell (
    .x     (sa[0]),
    .y     (sb[0]),
    .b_in  (bq),
    .diff  (cell_d),
    .b_out (cell_b)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Control FSM, datapath shift registers and registered outputs.
  // NOTE: every register here is state, so all assignments are non-blocking;
  // mixing in blocking assignments would make the result depend on
  // statement order and simulate differently from the synthesised netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      bq         <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            bq    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          sr  <= {cell_d, sr[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bq  <= cell_b;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            // The final bit is folded in directly so diff is complete now.
            diff       <= {cell_d, sr[WIDTH-1:1]};
            borrow_out <= cell_b;
            // Signed overflow: operands of opposite sign and the result
            // sign differs from the minuend sign.
            overflow   <= (a_msb != b_msb) && (cell_d != a_msb);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor
